// File: rtl/coeff_token_ctrl.sv
`timescale 1ns/1ps
// coeff_token_ctrl
// Sequencer for one CAVLC coeff_token parse per residual block. It picks the
// VLC table from nC (or decodes the 6-bit fixed-length code itself for
// nC >= 8), registers the LUT result, asks the bitstream buffer to consume the
// code, and hands TotalCoeff/TrailingOnes to the level/run decoder.
//
// Ports:
//   Clk, nReset                 clock, asynchronous active-low reset
//   Start, nC, ChromaDC, Busy   parse request (sampled only when idle), busy flag
//   Bits, BitsValid             bitstream window (MSB first) and its valid flag
//   ShiftReq, ShiftAmt, ShiftAck  consume request to the bitstream buffer
//   TableSel, LutBits           query to the shared coeff_token LUT bank
//   LutTotalCoeff, LutTrailingOnes, LutNumShift  LUT answer (NumShift 0 = no code)
//   OutValid, OutReady          result handshake to the residual decoder
//   TotalCoeff, TrailingOnes, Error  result payload
module coeff_token_ctrl #(
  parameter int WIN = 16
) (
  input  logic           Clk,
  input  logic           nReset,
  input  logic           Start,
  input  logic [4:0]     nC,
  input  logic           ChromaDC,
  output logic           Busy,
  input  logic [WIN-1:0] Bits,
  input  logic           BitsValid,
  output logic           ShiftReq,
  output logic [4:0]     ShiftAmt,
  input  logic           ShiftAck,
  output logic [2:0]     TableSel,
  output logic [WIN-1:0] LutBits,
  input  logic [4:0]     LutTotalCoeff,
  input  logic [1:0]     LutTrailingOnes,
  input  logic [4:0]     LutNumShift,
  output logic           OutValid,
  input  logic           OutReady,
  output logic [4:0]     TotalCoeff,
  output logic [1:0]     TrailingOnes,
  output logic           Error
);

  // One-hot encoding so Busy/ShiftReq/OutValid come straight off flops.
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_FETCH  = 5'b00010,
    S_LOOKUP = 5'b00100,
    S_SHIFT  = 5'b01000,
    S_OUT    = 5'b10000
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic       r_flc;
  logic [2:0] r_table_sel;
  logic [4:0] r_shift_amt;
  logic [4:0] r_total_coeff;
  logic [1:0] r_trailing_ones;
  logic       r_error;

  // Table choice from the request. nC above 16 still lands in the FLC range.
  logic [2:0] w_start_sel;
  logic       w_start_flc;

  always_comb begin
    w_start_flc = 1'b0;
    if (ChromaDC) begin
      w_start_sel = 3'd4;
    end else if (nC < 5'd2) begin
      w_start_sel = 3'd0;
    end else if (nC < 5'd4) begin
      w_start_sel = 3'd1;
    end else if (nC < 5'd8) begin
      w_start_sel = 3'd2;
    end else begin
      w_start_sel = 3'd3;
      w_start_flc = 1'b1;
    end
  end

  // Fixed-length code {x[3:0], y[1:0]}; 000011 is the escape for "no coefficients".
  logic [5:0] w_flc_code;
  logic [3:0] w_flc_x;
  logic [1:0] w_flc_y;
  logic       w_flc_zero;
  logic [4:0] w_flc_tc;
  logic       w_flc_err;

  assign w_flc_code = Bits[WIN-1 -: 6];
  assign w_flc_x    = w_flc_code[5:2];
  assign w_flc_y    = w_flc_code[1:0];
  assign w_flc_zero = (w_flc_code == 6'b000011);
  assign w_flc_tc   = w_flc_zero ? 5'd0 : ({1'b0, w_flc_x} + 5'd1);
  assign w_flc_err  = !w_flc_zero &&
                      (({3'b000, w_flc_y} > w_flc_tc) ||
                       ((w_flc_y == 2'd3) && (w_flc_x == 4'd0)));

  // Result selected by mode; an invalid code forces a zero payload.
  logic [4:0] w_res_tc;
  logic [1:0] w_res_t1;
  logic [4:0] w_res_amt;
  logic       w_res_err;

  always_comb begin
    if (r_flc) begin
      w_res_err = w_flc_err;
      w_res_tc  = w_flc_tc;
      w_res_t1  = w_flc_zero ? 2'd0 : w_flc_y;
      w_res_amt = 5'd6;
    end else begin
      w_res_err = (LutNumShift == 5'd0);
      w_res_tc  = LutTotalCoeff;
      w_res_t1  = LutTrailingOnes;
      w_res_amt = LutNumShift;
    end
    if (w_res_err) begin
      w_res_tc = 5'd0;
      w_res_t1 = 2'd0;
    end
  end

  // State register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (Start)     w_state_next = S_FETCH;
      S_FETCH:  if (BitsValid) w_state_next = S_LOOKUP;
      S_LOOKUP: w_state_next = w_res_err ? S_OUT : S_SHIFT;
      S_SHIFT:  if (ShiftAck)  w_state_next = S_OUT;
      S_OUT:    if (OutReady)  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy     = ~r_state[0];
    ShiftReq = r_state[3];
    OutValid = r_state[4];
  end

  // Datapath registers: table choice at Start, result capture in LOOKUP.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_flc           <= 1'b0;
      r_table_sel     <= 3'd0;
      r_shift_amt     <= 5'd0;
      r_total_coeff   <= 5'd0;
      r_trailing_ones <= 2'd0;
      r_error         <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && Start) begin
        r_flc       <= w_start_flc;
        r_table_sel <= w_start_sel;
      end
      if (r_state == S_LOOKUP) begin
        r_shift_amt     <= w_res_amt;
        r_total_coeff   <= w_res_tc;
        r_trailing_ones <= w_res_t1;
        r_error         <= w_res_err;
      end
    end
  end

  assign TableSel     = r_table_sel;
  assign ShiftAmt     = r_shift_amt;
  assign TotalCoeff   = r_total_coeff;
  assign TrailingOnes = r_trailing_ones;
  assign Error        = r_error;
  assign LutBits      = Bits;

endmodule

// File: tb/tb_coeff_token_ctrl.sv
`timescale 1ns/1ps
module tb_coeff_token_ctrl;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        Start;
  logic [4:0]  nC;
  logic        ChromaDC;
  logic        Busy;
  logic [15:0] Bits;
  logic        BitsValid;
  logic        ShiftReq;
  logic [4:0]  ShiftAmt;
  logic        ShiftAck;
  logic [2:0]  TableSel;
  logic [15:0] LutBits;
  logic [4:0]  LutTotalCoeff;
  logic [1:0]  LutTrailingOnes;
  logic [4:0]  LutNumShift;
  logic        OutValid;
  logic        OutReady;
  logic [4:0]  TotalCoeff;
  logic [1:0]  TrailingOnes;
  logic        Error;

  int checks = 0;
  int errors = 0;

  // LUT bank model: answers only when queried with the expected table and the
  // live window, otherwise reports "no code".
  logic [2:0] exp_sel = 3'd0;
  logic [4:0] lut_tc  = 5'd0;
  logic [1:0] lut_t1  = 2'd0;
  logic [4:0] lut_ns  = 5'd0;
  logic       lut_hit;

  assign lut_hit         = (TableSel == exp_sel) && (LutBits === Bits);
  assign LutTotalCoeff   = lut_hit ? lut_tc : 5'd0;
  assign LutTrailingOnes = lut_hit ? lut_t1 : 2'd0;
  assign LutNumShift     = lut_hit ? lut_ns : 5'd0;

  coeff_token_ctrl #(.WIN(16)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .nC(nC), .ChromaDC(ChromaDC),
    .Busy(Busy), .Bits(Bits), .BitsValid(BitsValid), .ShiftReq(ShiftReq),
    .ShiftAmt(ShiftAmt), .ShiftAck(ShiftAck), .TableSel(TableSel), .LutBits(LutBits),
    .LutTotalCoeff(LutTotalCoeff), .LutTrailingOnes(LutTrailingOnes),
    .LutNumShift(LutNumShift), .OutValid(OutValid), .OutReady(OutReady),
    .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .Error(Error)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full parse with configurable stalls; every expectation comes from the
  // coding rules applied to the request, not from the DUT.
  task automatic run_parse(input int nc, input bit chroma, input logic [15:0] bits,
                           input int ltc, input int lt1, input int lns,
                           input int bv_dly, input int ack_dly, input int rdy_dly,
                           input bit chk_lat);
    int nce, v, x, y, e_sel, e_tc, e_t1, e_amt;
    bit flc, e_err, done;
    int cyc, shifts, sh_first, out_first;
    logic [4:0] sh_amt;
    logic [4:0] held_tc;
    logic [1:0] held_t1;
    logic       held_err;

    nce = (nc > 16) ? 16 : nc;
    flc = 1'b0;
    if (chroma)        e_sel = 4;
    else if (nce < 2)  e_sel = 0;
    else if (nce < 4)  e_sel = 1;
    else if (nce < 8)  e_sel = 2;
    else begin         e_sel = 3; flc = 1'b1; end

    if (flc) begin
      v = int'(bits[15:10]);
      x = v / 4;
      y = v % 4;
      if (v == 3) begin
        e_tc = 0; e_t1 = 0; e_err = 1'b0;
      end else begin
        e_tc = x + 1; e_t1 = y;
        e_err = (y > e_tc) || (y == 3 && x == 0);
      end
      e_amt = 6;
    end else begin
      e_err = (lns == 0);
      e_tc = ltc; e_t1 = lt1; e_amt = lns;
    end
    if (e_err) begin e_tc = 0; e_t1 = 0; end

    exp_sel = 3'(e_sel);
    lut_tc  = 5'(ltc);
    lut_t1  = 2'(lt1);
    lut_ns  = 5'(lns);

    Bits = bits; BitsValid = (bv_dly == 0);
    nC = 5'(nc); ChromaDC = chroma;
    ShiftAck = 1'b0; OutReady = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; nC = 5'($urandom); ChromaDC = 1'($urandom);
    check("busy_after_start", Busy, 1);
    check("table_sel", TableSel, e_sel);

    cyc = 1; done = 1'b0; shifts = 0; sh_first = -1; out_first = -1;
    sh_amt = 5'd0; held_tc = 5'd0; held_t1 = 2'd0; held_err = 1'b0;
    while (!done && cyc < 100) begin
      BitsValid = (cyc > bv_dly);
      Start = 1'($urandom);
      check("busy_hold", Busy, 1);
      if (ShiftReq) begin
        if (sh_first < 0) begin
          sh_first = cyc; sh_amt = ShiftAmt;
          check("shift_amt", ShiftAmt, e_amt);
        end else begin
          check("shift_amt_stable", ShiftAmt, sh_amt);
        end
        ShiftAck = ((cyc - sh_first) >= ack_dly);
        if (ShiftAck) shifts++;
        Bits = 16'($urandom);
      end else begin
        ShiftAck = 1'($urandom);
      end
      if (OutValid) begin
        if (out_first < 0) begin
          out_first = cyc;
          held_tc = TotalCoeff; held_t1 = TrailingOnes; held_err = Error;
          check("total_coeff", TotalCoeff, e_tc);
          check("trailing_ones", TrailingOnes, e_t1);
          check("error", Error, e_err);
          check("table_sel_held", TableSel, e_sel);
        end else begin
          check("out_stable", {TotalCoeff, TrailingOnes, Error}, {held_tc, held_t1, held_err});
        end
        OutReady = ((cyc - out_first) >= rdy_dly);
        if (OutReady) done = 1'b1;
        Bits = 16'($urandom);
      end else begin
        OutReady = 1'($urandom);
      end
      @(posedge Clk); #1;
      cyc++;
    end
    Start = 1'b0; ShiftAck = 1'b0; OutReady = 1'b0;

    check("completed", done, 1);
    check("shift_count", shifts, e_err ? 0 : 1);
    check("idle_busy", Busy, 0);
    check("idle_outvalid", OutValid, 0);
    check("idle_shiftreq", ShiftReq, 0);
    if (chk_lat) begin
      check("lat_shift", sh_first, e_err ? -1 : 3);
      check("lat_out", out_first, e_err ? 3 : 4);
      check("lat_idle", cyc, e_err ? 4 : 5);
    end
    $display("parse nC=%0d chroma=%0d bits=%04h sel=%0d -> tc=%0d t1=%0d err=%0d amt=%0d shifts=%0d",
             nc, chroma, bits, e_sel, e_tc, e_t1, e_err, e_amt, shifts);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nReset = 1'b0; Start = 1'b0; nC = 5'd0; ChromaDC = 1'b0;
    Bits = 16'd0; BitsValid = 1'b0; ShiftAck = 1'b0; OutReady = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", Busy, 0);
    check("rst_shiftreq", ShiftReq, 0);
    check("rst_outvalid", OutValid, 0);
    check("rst_error", Error, 0);
    check("rst_payload", {ShiftAmt, TotalCoeff, TrailingOnes, TableSel}, 0);
    nReset = 1'b1;
    @(posedge Clk); #1;

    // LUT path, minimum latency
    run_parse(1, 1'b0, 16'hA5C3, 3, 3, 5, 0, 0, 0, 1'b1);
    // FLC path
    run_parse(9, 1'b0, 16'b0011_1000_0000_0000, 0, 0, 7, 0, 0, 0, 1'b1);
    run_parse(9, 1'b0, 16'b0000_1111_1111_1111, 0, 0, 7, 0, 0, 0, 1'b0);
    // Invalid codes
    run_parse(5, 1'b0, 16'h1234, 2, 1, 0, 0, 0, 0, 1'b1);
    run_parse(20, 1'b0, 16'b0001_1100_0000_0000, 0, 0, 9, 0, 0, 0, 1'b1);
    // Stalls on every handshake, chroma DC table
    run_parse(12, 1'b1, 16'h7E01, 2, 1, 4, 3, 2, 4, 1'b0);

    // Asynchronous reset while waiting in SHIFT
    exp_sel = 3'd0; lut_tc = 5'd2; lut_t1 = 2'd1; lut_ns = 5'd3;
    Bits = 16'hBEEF; BitsValid = 1'b1; nC = 5'd1; ChromaDC = 1'b0;
    ShiftAck = 1'b0; OutReady = 1'b0; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    n = 0;
    while (!ShiftReq && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("reached_shift", ShiftReq, 1);
    #2 nReset = 1'b0;
    #1;
    check("arst_shiftreq", ShiftReq, 0);
    check("arst_busy", Busy, 0);
    check("arst_outvalid", OutValid, 0);
    check("arst_payload", {ShiftAmt, TotalCoeff, TrailingOnes, TableSel, Error}, 0);
    @(posedge Clk); #3;
    nReset = 1'b1;
    @(posedge Clk); #1;
    check("post_rst_idle", Busy, 0);
    run_parse(3, 1'b0, 16'h0F0F, 7, 2, 11, 0, 0, 0, 1'b1);

    // Randomized parses
    for (int i = 0; i < 24; i++) begin
      run_parse($urandom_range(0, 31), ($urandom_range(0, 3) == 0), 16'($urandom),
                $urandom_range(0, 16), $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 16),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
